// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared constants and the one-hot helper used by the demux slice.
//
//   DEMUX_SEL_W_DEF / DEMUX_OUT_W_DEF : default select width / output count.
//   DEMUX_MAX_SEL_W / DEMUX_MAX_OUT_W : widest select the helper supports.
//   onehot(sel, outW)                 : vector with bit sel set, or all
//                                       zero when sel >= outW.
//
//   Optional feature macro used by the slice: DEMUX_ERR_EN.
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int DEMUX_SEL_W_DEF = 3;
    localparam int DEMUX_OUT_W_DEF = 8;

    // The helper works on a fixed maximum width so it can be shared by any
    // parameterisation; callers narrow the result with a size cast.
    localparam int DEMUX_MAX_SEL_W = 8;
    localparam int DEMUX_MAX_OUT_W = 1 << DEMUX_MAX_SEL_W;

    // Binary index to one-hot.  An index at or above outW is never wrapped
    // or masked into range; it simply produces an all-zero vector.
    function automatic logic [DEMUX_MAX_OUT_W-1:0] onehot(
        input logic [DEMUX_MAX_SEL_W-1:0] sel,
        input int                         outW
    );
        logic [DEMUX_MAX_OUT_W-1:0] vec;
        vec = '0;
        if (int'(sel) < outW) begin
            vec[sel] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/demux_decode.sv
// ---------------------------------------------------------------------------
// demux_decode
//   Purely combinational select-to-one-hot decoder with range check.
//
//   Parameters : SEL_W (select width, <= DEMUX_MAX_SEL_W), OUT_W (outputs)
//   Ports      : sel_i    [SEL_W-1:0]  binary select
//                onehot_o [OUT_W-1:0]  one-hot decode, zero if out of range
//                err_o                 sel_i >= OUT_W (only with DEMUX_ERR_EN)
// ---------------------------------------------------------------------------
module demux_decode
    import demux_pkg::*;
#(
    parameter int SEL_W = DEMUX_SEL_W_DEF,
    parameter int OUT_W = DEMUX_OUT_W_DEF
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [OUT_W-1:0] onehot_o
`ifdef DEMUX_ERR_EN
    ,
    output logic             err_o
`endif
);

    // The shared helper returns the widest vector; only the low OUT_W bits
    // are meaningful here, so the cast drops the rest.
    always_comb begin
        onehot_o = OUT_W'(onehot(DEMUX_MAX_SEL_W'(sel_i), OUT_W));
    end

`ifdef DEMUX_ERR_EN
    // Out-of-range flag.  When OUT_W covers every select code this folds to
    // a constant zero.
    always_comb begin
        err_o = (int'(sel_i) >= OUT_W);
    end
`endif

endmodule

// File: rtl/demux.sv
// ---------------------------------------------------------------------------
// demux
//   Registered 1-of-N output demultiplexer (binary-to-one-hot decoder).
//   yy takes one-hot(sel) on every rising clk edge; it is driven straight
//   from flops so there is no combinational path from sel to yy.
//
//   Parameters : SEL_W (default 3), OUT_W (default 8, 1..2**SEL_W)
//   Ports (declaration order is fixed for positional instantiation):
//     yy      [OUT_W-1:0] out  registered one-hot output
//     clk                 in   rising-edge clock
//     sel     [SEL_W-1:0] in   binary index of the output to assert
//     rst_n               in   asynchronous active-low reset
//     sel_err             out  registered sel >= OUT_W flag
//                              (present only when DEMUX_ERR_EN is defined)
// ---------------------------------------------------------------------------
module demux
    import demux_pkg::*;
#(
    parameter int SEL_W = DEMUX_SEL_W_DEF,
    parameter int OUT_W = DEMUX_OUT_W_DEF
) (
    output logic [OUT_W-1:0] yy,
    input  logic             clk,
    input  logic [SEL_W-1:0] sel,
    input  logic             rst_n
`ifdef DEMUX_ERR_EN
    ,
    output logic             sel_err
`endif
);

    logic [OUT_W-1:0] yy_d;
    logic [OUT_W-1:0] yy_q;

`ifdef DEMUX_ERR_EN
    logic sel_err_d;
    logic sel_err_q;
`endif

    demux_decode #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_decode (
        .sel_i    (sel),
        .onehot_o (yy_d)
`ifdef DEMUX_ERR_EN
        ,
        .err_o    (sel_err_d)
`endif
    );

    // Output register.  Reset clears the outputs immediately without waiting
    // for a clock; afterwards the decode is captured once per rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yy_q <= '0;
        end else begin
            yy_q <= yy_d;
        end
    end

`ifdef DEMUX_ERR_EN
    // The error flag is registered alongside yy so both describe the same
    // captured select value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

    assign yy = yy_q;

endmodule

// File: tb/tb_demux.sv
// ---------------------------------------------------------------------------
// tb_demux
//   Self-checking bench for demux.  Two instances share clk/rst_n/sel: one
//   with the default 8 outputs and one with 6 outputs so that select codes
//   6 and 7 are out of range.  Build with DEMUX_ERR_EN to also cover sel_err.
// ---------------------------------------------------------------------------
module tb_demux;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sel   = 3'd0;

    logic [7:0] yy8;
    logic [5:0] yy6;
`ifdef DEMUX_ERR_EN
    logic       err8;
    logic       err6;
`endif

    int total = 0;
    int bad   = 0;

    demux #(
        .SEL_W (3),
        .OUT_W (8)
    ) dut8 (
        .yy      (yy8),
        .clk     (clk),
        .sel     (sel),
        .rst_n   (rst_n)
`ifdef DEMUX_ERR_EN
        ,
        .sel_err (err8)
`endif
    );

    demux #(
        .SEL_W (3),
        .OUT_W (6)
    ) dut6 (
        .yy      (yy6),
        .clk     (clk),
        .sel     (sel),
        .rst_n   (rst_n)
`ifdef DEMUX_ERR_EN
        ,
        .sel_err (err6)
`endif
    );

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference model: what each output must hold after the most recent
    // event, computed directly from the select value with shifts.
    logic [7:0] exp8    = 8'h00;
    logic [5:0] exp6    = 6'h00;
    logic       expErr6 = 1'b0;
    int         lastSel = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8    = 8'h00;
            exp6    = 6'h00;
            expErr6 = 1'b0;
            lastSel = -1;
        end else begin
            lastSel = int'(sel);
            exp8    = 8'(1 << lastSel);
            exp6    = (lastSel < 6) ? 6'(1 << lastSel) : 6'h00;
            expErr6 = (lastSel >= 6);
        end
    end

    // Single comparison point: counts the check and reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive a new select shortly after an edge, then let one edge capture it
    // and return 1 time unit later so outputs can be inspected.
    task automatic applyStimulus(input logic [2:0] s);
        sel = s;
        @(posedge clk);
        #1;
    endtask

    // Continuous comparison against the model on every falling edge, midway
    // between updates, plus the one-hot invariant for in-range selects.
    always @(negedge clk) begin
        checkOutput("model yy8", 32'(yy8), 32'(exp8));
        checkOutput("model yy6", 32'(yy6), 32'(exp6));
`ifdef DEMUX_ERR_EN
        checkOutput("model err8", 32'(err8), 32'd0);
        checkOutput("model err6", 32'(err6), 32'(expErr6));
`endif
        if (lastSel >= 0) begin
            checkOutput("onehot yy8", 32'($countones(yy8)), 32'd1);
            if (lastSel < 6) begin
                checkOutput("onehot yy6", 32'($countones(yy6)), 32'd1);
            end
        end
    end

    logic [7:0] sweepExp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        // Reset held across several clock edges.
        #1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset yy8", 32'(yy8), 32'h00);
        checkOutput("reset yy6", 32'(yy6), 32'h00);
`ifdef DEMUX_ERR_EN
        checkOutput("reset err6", 32'(err6), 32'd0);
`endif
        rst_n = 1'b1;

        // Sweep every select code once per edge.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i));
            checkOutput("sweep yy8", 32'(yy8), 32'(sweepExp[i]));
        end

        // Latency and hold: a mid-cycle sel change waits for the next edge.
        applyStimulus(3'd2);
        checkOutput("hold before", 32'(yy8), 32'h04);
        #2;
        sel = 3'd5;
        #1;
        checkOutput("hold mid", 32'(yy8), 32'h04);
        @(posedge clk);
        #1;
        checkOutput("hold after", 32'(yy8), 32'h20);

        // Asynchronous reset between edges clears without a clock.
        applyStimulus(3'd7);
        checkOutput("pre reset yy8", 32'(yy8), 32'h80);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst yy8", 32'(yy8), 32'h00);
        checkOutput("async rst yy6", 32'(yy6), 32'h00);
        #1;
        rst_n = 1'b1;
        applyStimulus(3'd3);
        checkOutput("post reset yy8", 32'(yy8), 32'h08);

        // Out-of-range select on the 6-output instance.
        applyStimulus(3'd6);
        checkOutput("oor yy6", 32'(yy6), 32'h00);
`ifdef DEMUX_ERR_EN
        checkOutput("oor err6", 32'(err6), 32'd1);
`endif
        applyStimulus(3'd5);
        checkOutput("msb yy6", 32'(yy6), 32'h20);
`ifdef DEMUX_ERR_EN
        checkOutput("msb err6", 32'(err6), 32'd0);
`endif
        applyStimulus(3'd0);
        checkOutput("lsb yy6", 32'(yy6), 32'h01);

        // Random select traffic, checked by the falling-edge comparator.
        repeat (1000) begin
            applyStimulus(3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux.md
Name: demux

Overview:
- Registered 1-of-N output demultiplexer (binary-to-one-hot decoder).
- On each rising clock edge, the output bit selected by `sel` is driven high and all other bits are driven low.
- Used as a select/strobe generator that fans one control source out to up to 2**SEL_W destinations.
- Single clock domain, asynchronous active-low reset.

Parameters:
- SEL_W, 3, width of the binary select input.
- OUT_W, 8, number of one-hot outputs; legal range 1 to 2**SEL_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  SEL_W  binary index of the output to assert.
- yy  output  OUT_W  registered one-hot output.
- sel_err  output  1  registered out-of-range flag; present only with DEMUX_ERR_EN.
- Declaration order is fixed for positional instantiation: yy, clk, sel, rst_n, then sel_err.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - rst_n low: yy = 0 immediately, independent of clk. sel_err = 0 when present.
  - rst_n deasserts asynchronously; the first update occurs on the first rising clk edge with rst_n high.
- Normal operation:
  - At each rising clk edge: yy <= one-hot(sel), i.e. bit sel = 1 and all other bits = 0.
  - Latency: 1 clock edge. yy is stable between edges.
  - A change on sel between edges has no effect on yy until the next edge.
- Output rules:
  - Exactly one bit of yy is set whenever sel < OUT_W.
  - yy is all-zero only under reset or when sel >= OUT_W. This case is reachable only when OUT_W < 2**SEL_W.
  - No glitches: yy comes directly from flops, with no combinational path from sel to yy.
- Boundary conditions:
  - sel = 0 gives yy = 1 (LSB). sel = OUT_W-1 gives MSB set.
  - The same sel held across edges keeps yy constant.
  - Reset asserted mid-operation clears yy within the same timestep.
  - sel is unsigned with no wrap-around. An out-of-range value yields zero and is never masked or modulo'd.

Optional Feature:
- Macro: DEMUX_ERR_EN.
- Defined:
  - sel_err port exists and is registered alongside yy.
  - sel_err <= (sel >= OUT_W) at each rising edge; it is 0 in reset.
  - When OUT_W == 2**SEL_W, sel_err is constant 0.
- Undefined:
  - No sel_err port.
  - Out-of-range sel silently gives yy = 0.

Decomposition:
- Package demux_pkg holds:
  - constant DEMUX_SEL_W_DEF = 3 and constant DEMUX_OUT_W_DEF = 8;
  - function onehot(sel), returning the OUT_W-bit vector with bit sel set, or 0 when out of range.
- One natural sub-module, demux_decode: purely combinational sel-to-one-hot decoder plus range check.
- The top-level demux holds the output register and reset.

Test Plan:
- Reset: hold rst_n = 0 and toggle clk -> yy = 8'b0000_0000; sel_err = 0 when present.
- Sweep: release reset, apply sel = 0..7, one value per rising edge -> after each edge yy = 8'b0000_0001, 0000_0010, ... 1000_0000 respectively.
- Latency/hold: with yy = 0000_0100 (sel = 2), change sel to 5 mid-cycle -> yy stays 0000_0100 until the next edge, then becomes 0010_0000.
- Async reset mid-run: with yy = 1000_0000, pull rst_n low between edges -> yy = 0 immediately without a clock. Release, sel = 3, one edge -> yy = 0000_1000.
- Out of range: parameters OUT_W = 6, SEL_W = 3.
  - sel = 6 at an edge -> yy = 6'b000000, and sel_err = 1 with DEMUX_ERR_EN.
  - Then sel = 5 -> yy = 6'b100000, sel_err = 0.
- One-hot invariant: random sel for 1000 cycles -> $countones(yy) == 1 after every edge with sel < OUT_W.
